mario_hit_detector: RTL and testbench

MARIO_HIT_DETECTOR -- requirements
Module: mario_hit_detector

---
 rtl/mario_pkg.sv | 27 ++
 rtl/mario_edge_classifier.sv | 39 +++
 rtl/mario_hit_detector.sv | 191 +++++++++++++++++++
 tb/tb_mario_hit_detector.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mario_pkg.sv
// -----------------------------------------------------------------------------
// mario_pkg
// Shared definitions for the Mario hit-detection slice:
//   - hit FSM state encoding
//   - bit positions inside the 4-bit edge code (Left-Top-Right-Bottom)
//   - pixel offset and brick index widths
// -----------------------------------------------------------------------------
package mario_pkg;

    // Widths of the per-pixel inputs
    localparam int OFFSET_W    = 11;
    localparam int BRICK_IDX_W = 6;

    // Edge code bit positions, bit3..bit0 = Left, Top, Right, Bottom
    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        HIT      = 2'd1,
        COOLDOWN = 2'd2,
        FROZEN   = 2'd3
    } hit_state_t;

endpackage

// File: rtl/mario_edge_classifier.sv
// -----------------------------------------------------------------------------
// mario_edge_classifier
// Purely combinational: classifies a pixel offset inside the Mario sprite into
// the edge bands it falls in. Corner pixels set two bits, interior pixels
// give 4'b0000.
//
// Parameters:
//   OBJECT_WIDTH, OBJECT_HEIGHT - sprite size in pixels
//   EDGE_MARGIN                 - depth of each edge band in pixels
// Ports:
//   offsetX  in  [10:0] pixel X relative to sprite top-left
//   offsetY  in  [10:0] pixel Y relative to sprite top-left
//   edgeCode out [3:0]  Left-Top-Right-Bottom (bit3..bit0)
// -----------------------------------------------------------------------------
module mario_edge_classifier
    import mario_pkg::*;
#(
    parameter int OBJECT_WIDTH  = 64,
    parameter int OBJECT_HEIGHT = 64,
    parameter int EDGE_MARGIN   = 8
) (
    input  logic [OFFSET_W-1:0] offsetX,
    input  logic [OFFSET_W-1:0] offsetY,
    output logic [3:0]          edgeCode
);

    localparam logic [OFFSET_W-1:0] NEAR_LIM   = OFFSET_W'(EDGE_MARGIN);
    localparam logic [OFFSET_W-1:0] RIGHT_LIM  = OFFSET_W'(OBJECT_WIDTH - EDGE_MARGIN);
    localparam logic [OFFSET_W-1:0] BOTTOM_LIM = OFFSET_W'(OBJECT_HEIGHT - EDGE_MARGIN);

    always_comb begin
        edgeCode              = 4'b0000;
        edgeCode[EDGE_LEFT]   = (offsetX <  NEAR_LIM);
        edgeCode[EDGE_TOP]    = (offsetY <  NEAR_LIM);
        edgeCode[EDGE_RIGHT]  = (offsetX >= RIGHT_LIM);
        edgeCode[EDGE_BOTTOM] = (offsetY >= BOTTOM_LIM);
    end

endmodule

// File: rtl/mario_hit_detector.sv
// -----------------------------------------------------------------------------
// mario_hit_detector
// Watches the pixel stream for Mario overlapping a brick, border or the floor
// and issues registered one-cycle pulses (1 clk after the qualifying pixel).
// At most one event is reported per frame; a floor touch costs a life.
//
// Build option: define MARIO_HIT_COOLDOWN_EN to give Mario COOLDOWN_FRAMES
// frames of immunity after a life loss. Without it, a floor touch behaves like
// any other hit and detection re-arms on the next startOfFrame.
//
// Parameters:
//   OBJECT_WIDTH, OBJECT_HEIGHT - sprite size in pixels
//   EDGE_MARGIN                 - edge-band depth in pixels
//   COOLDOWN_FRAMES             - immunity frames after a life loss
// Ports:
//   clk, reset (async, active high)
//   startOfFrame                - 1-cycle pulse at each frame start
//   marioDrawReq, brickDrawReq, borderDrawReq, floorDrawReq - pixel owners
//   offsetX, offsetY [10:0]     - pixel offset from Mario top-left
//   brickIndex [5:0]            - brick drawn at this pixel
//   win                         - freezes detection until reset
//   collision, lifeLost, brickHit - 1-cycle pulses
//   HitEdgeCode [3:0], brickHitIndex [5:0] - held between pulses
// -----------------------------------------------------------------------------
module mario_hit_detector
    import mario_pkg::*;
#(
    parameter int OBJECT_WIDTH    = 64,
    parameter int OBJECT_HEIGHT   = 64,
    parameter int EDGE_MARGIN     = 8,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   marioDrawReq,
    input  logic                   brickDrawReq,
    input  logic                   borderDrawReq,
    input  logic                   floorDrawReq,
    input  logic [OFFSET_W-1:0]    offsetX,
    input  logic [OFFSET_W-1:0]    offsetY,
    input  logic [BRICK_IDX_W-1:0] brickIndex,
    input  logic                   win,
    output logic                   collision,
    output logic [3:0]             HitEdgeCode,
    output logic                   lifeLost,
    output logic                   brickHit,
    output logic [BRICK_IDX_W-1:0] brickHitIndex
);

    // Elaboration-time sanity check of the configuration
    if (COOLDOWN_FRAMES < 1 || EDGE_MARGIN > OBJECT_WIDTH || EDGE_MARGIN > OBJECT_HEIGHT)
    begin : g_bad_cfg
        $error("mario_hit_detector: invalid parameter combination");
    end

    hit_state_t state_q, state_d;

    logic                   collision_q, collision_d;
    logic                   life_lost_q, life_lost_d;
    logic                   brick_hit_q, brick_hit_d;
    logic [3:0]             edge_code_q, edge_code_d;
    logic [BRICK_IDX_W-1:0] brick_idx_q, brick_idx_d;

    logic [3:0] pixel_edge;
    logic       floor_overlap;
    logic       solid_overlap;

`ifdef MARIO_HIT_COOLDOWN_EN
    localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

    mario_edge_classifier #(
        .OBJECT_WIDTH  (OBJECT_WIDTH),
        .OBJECT_HEIGHT (OBJECT_HEIGHT),
        .EDGE_MARGIN   (EDGE_MARGIN)
    ) u_edge_classifier (
        .offsetX  (offsetX),
        .offsetY  (offsetY),
        .edgeCode (pixel_edge)
    );

    // Floor wins over a coincident brick/border on the same pixel
    assign floor_overlap = marioDrawReq & floorDrawReq;
    assign solid_overlap = marioDrawReq & (brickDrawReq | borderDrawReq) & ~floorDrawReq;

    always_comb begin
        state_d     = state_q;
        collision_d = 1'b0;
        life_lost_d = 1'b0;
        brick_hit_d = 1'b0;
        edge_code_d = edge_code_q;
        brick_idx_d = brick_idx_q;
`ifdef MARIO_HIT_COOLDOWN_EN
        frame_cnt_d = frame_cnt_q;
`endif

        if (win) begin
            state_d = FROZEN;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (floor_overlap) begin
                        life_lost_d = 1'b1;
`ifdef MARIO_HIT_COOLDOWN_EN
                        state_d     = COOLDOWN;
                        frame_cnt_d = '0;
`else
                        state_d     = HIT;
`endif
                    end else if (solid_overlap) begin
                        collision_d = 1'b1;
                        edge_code_d = pixel_edge;
                        state_d     = HIT;
                        if (brickDrawReq) begin
                            brick_hit_d = 1'b1;
                            brick_idx_d = brickIndex;
                        end
                    end
                end

                // Any overlap on the re-arming pixel itself is dropped
                HIT: begin
                    if (startOfFrame) begin
                        state_d = ARMED;
                    end
                end

                COOLDOWN: begin
`ifdef MARIO_HIT_COOLDOWN_EN
                    if (startOfFrame) begin
                        if (frame_cnt_q == CNT_W'(COOLDOWN_FRAMES - 1)) begin
                            state_d     = ARMED;
                            frame_cnt_d = '0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        end
                    end
`else
                    // Unreachable without the cooldown option; recover safely
                    state_d = ARMED;
`endif
                end

                FROZEN: begin
                    state_d = FROZEN;
                end

                default: begin
                    state_d = ARMED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARMED;
            collision_q <= 1'b0;
            life_lost_q <= 1'b0;
            brick_hit_q <= 1'b0;
            edge_code_q <= 4'b0000;
            brick_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            collision_q <= collision_d;
            life_lost_q <= life_lost_d;
            brick_hit_q <= brick_hit_d;
            edge_code_q <= edge_code_d;
            brick_idx_q <= brick_idx_d;
        end
    end

`ifdef MARIO_HIT_COOLDOWN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`endif

    assign collision     = collision_q;
    assign lifeLost      = life_lost_q;
    assign brickHit      = brick_hit_q;
    assign HitEdgeCode   = edge_code_q;
    assign brickHitIndex = brick_idx_q;

endmodule

// File: tb/tb_mario_hit_detector.sv
// -----------------------------------------------------------------------------
// tb_mario_hit_detector
// Directed self-checking bench for mario_hit_detector. Expected values are
// hand-computed from the edge-band rules with the default 64x64 sprite and
// 8-pixel margin. Cooldown scenario runs when MARIO_HIT_COOLDOWN_EN is defined.
// -----------------------------------------------------------------------------
module tb_mario_hit_detector;

    logic        clk;
    logic        reset;
    logic        startOfFrame;
    logic        marioDrawReq;
    logic        brickDrawReq;
    logic        borderDrawReq;
    logic        floorDrawReq;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [5:0]  brickIndex;
    logic        win;
    logic        collision;
    logic [3:0]  HitEdgeCode;
    logic        lifeLost;
    logic        brickHit;
    logic [5:0]  brickHitIndex;

    int n_checks = 0;
    int n_errors = 0;

    mario_hit_detector dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .marioDrawReq  (marioDrawReq),
        .brickDrawReq  (brickDrawReq),
        .borderDrawReq (borderDrawReq),
        .floorDrawReq  (floorDrawReq),
        .offsetX       (offsetX),
        .offsetY       (offsetY),
        .brickIndex    (brickIndex),
        .win           (win),
        .collision     (collision),
        .HitEdgeCode   (HitEdgeCode),
        .lifeLost      (lifeLost),
        .brickHit      (brickHit),
        .brickHitIndex (brickHitIndex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one pixel for one clock edge, then return the bus to idle.
    // Outputs are sampled 1 time unit after the edge by the caller.
    task automatic apply(input logic m, input logic br, input logic bo, input logic fl,
                         input logic sof, input logic w,
                         input logic [10:0] x, input logic [10:0] y, input logic [5:0] idx);
        marioDrawReq  = m;
        brickDrawReq  = br;
        borderDrawReq = bo;
        floorDrawReq  = fl;
        startOfFrame  = sof;
        win           = w;
        offsetX       = x;
        offsetY       = y;
        brickIndex    = idx;
        @(posedge clk);
        #1;
        marioDrawReq  = 1'b0;
        brickDrawReq  = 1'b0;
        borderDrawReq = 1'b0;
        floorDrawReq  = 1'b0;
        startOfFrame  = 1'b0;
        win           = 1'b0;
        offsetX       = '0;
        offsetY       = '0;
        brickIndex    = '0;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 6'd0);
    endtask

    task automatic sof();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 6'd0);
    endtask

    task automatic check_pulses(input string tag, input logic c, input logic l, input logic b);
        check({tag, ".collision"}, {31'd0, collision}, {31'd0, c});
        check({tag, ".lifeLost"},  {31'd0, lifeLost},  {31'd0, l});
        check({tag, ".brickHit"},  {31'd0, brickHit},  {31'd0, b});
    endtask

    task automatic check_regs(input string tag, input logic [3:0] code, input logic [5:0] idx);
        check({tag, ".edge"}, {28'd0, HitEdgeCode},   {28'd0, code});
        check({tag, ".idx"},  {26'd0, brickHitIndex}, {26'd0, idx});
    endtask

    initial begin
        reset = 1'b1;
        startOfFrame = 1'b0; marioDrawReq = 1'b0; brickDrawReq = 1'b0;
        borderDrawReq = 1'b0; floorDrawReq = 1'b0; win = 1'b0;
        offsetX = '0; offsetY = '0; brickIndex = '0;

        repeat (2) @(posedge clk);
        #1;
        check_pulses("reset", 1'b0, 1'b0, 1'b0);
        check_regs("reset", 4'b0000, 6'd0);
        reset = 1'b0;

        // Brick at (3,30): left band only
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd3, 11'd30, 6'd21);
        check_pulses("brick_3_30", 1'b1, 1'b0, 1'b1);
        check_regs("brick_3_30", 4'b1000, 6'd21);
        idle();
        check_pulses("brick_after", 1'b0, 1'b0, 1'b0);
        check_regs("brick_hold", 4'b1000, 6'd21);

        // Border at (60,2): top-right corner
        sof();
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd60, 11'd2, 6'd0);
        check_pulses("border_60_2", 1'b1, 1'b0, 1'b0);
        check_regs("border_60_2", 4'b0110, 6'd21);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd10, 11'd10, 6'd0);
        check_pulses("same_frame", 1'b0, 1'b0, 1'b0);
        check_regs("same_frame", 4'b0110, 6'd21);
        // Overlap coinciding with startOfFrame only re-arms
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'd10, 11'd10, 6'd7);
        check_pulses("sof_overlap", 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd10, 11'd60, 6'd0);
        check_pulses("rearmed", 1'b1, 1'b0, 1'b0);
        check_regs("rearmed", 4'b0001, 6'd21);

        // Edge band boundaries
        sof();
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd8, 11'd7, 6'd0);
        check_regs("bound_8_7", 4'b0100, 6'd21);
        sof();
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd56, 11'd55, 6'd0);
        check_regs("bound_56_55", 4'b0010, 6'd21);
        sof();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd7, 11'd56, 6'd33);
        check_pulses("bound_7_56", 1'b1, 1'b0, 1'b1);
        check_regs("bound_7_56", 4'b1001, 6'd33);

        // Floor and brick on one pixel: floor only
        sof();
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd30, 11'd30, 6'd5);
        check_pulses("floor_brick", 1'b0, 1'b1, 1'b0);
        check_regs("floor_brick", 4'b1001, 6'd33);
        idle();
        check_pulses("floor_after", 1'b0, 1'b0, 1'b0);

`ifdef MARIO_HIT_COOLDOWN_EN
        for (int i = 1; i <= 59; i++) begin
            sof();
            apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd30, 11'd30, 6'd0);
            check({"cooldown.lifeLost"}, {31'd0, lifeLost}, 32'd0);
        end
        sof();
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd30, 11'd30, 6'd0);
        check_pulses("frame61_floor", 1'b0, 1'b1, 1'b0);
`else
        sof();
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd30, 11'd30, 6'd0);
        check_pulses("next_frame_floor", 1'b0, 1'b1, 1'b0);
`endif
        // Async reset while lifeLost is high and the FSM is not armed
        reset = 1'b1;
        #1;
        check_pulses("async_reset", 1'b0, 1'b0, 1'b0);
        check_regs("async_reset", 4'b0000, 6'd0);
        @(negedge clk);
        reset = 1'b0;

        // Live immediately after release; interior pixel still collides
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd32, 11'd32, 6'd9);
        check_pulses("post_reset_32_32", 1'b1, 1'b0, 1'b1);
        check_regs("post_reset_32_32", 4'b0000, 6'd9);

        // win during HIT freezes everything until reset
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 11'd0, 6'd0);
        check_pulses("win", 1'b0, 1'b0, 1'b0);
        sof();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd3, 11'd3, 6'd12);
        check_pulses("frozen_brick", 1'b0, 1'b0, 1'b0);
        check_regs("frozen_brick", 4'b0000, 6'd9);
        sof();
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd3, 11'd3, 6'd0);
        check_pulses("frozen_floor", 1'b0, 1'b0, 1'b0);

        // Reset leaves FROZEN; win wins over a coincident overlap in ARMED
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd63, 11'd63, 6'd4);
        check_pulses("win_with_overlap", 1'b0, 1'b0, 1'b0);
        check_regs("win_with_overlap", 4'b0000, 6'd0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd63, 11'd63, 6'd4);
        check_pulses("unfrozen_63_63", 1'b1, 1'b0, 1'b1);
        check_regs("unfrozen_63_63", 4'b0011, 6'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
